// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//  Shared types and constants for the DMG timer sequencer.
//  - timer_state_t : TIMA overflow/reload FSM encoding
//  - TAP_*         : system-divider bit selected by TAC[1:0]
//  - tac_tap()     : maps TAC[1:0] to the divider bit index
// ---------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_OVF    = 2'd1,
    TS_RELOAD = 2'd2
  } timer_state_t;

  localparam int CNT_W_DEF = 14;

  // Divider bit per TAC[1:0]; the divider counts M-cycles (1 MHz).
  localparam int TAP_4K   = 7;  // TAC[1:0]=00, 4096 Hz
  localparam int TAP_262K = 1;  // TAC[1:0]=01
  localparam int TAP_65K  = 3;  // TAC[1:0]=10
  localparam int TAP_16K  = 5;  // TAC[1:0]=11

  function automatic int unsigned tac_tap(input logic [1:0] sel);
    int unsigned idx;
    case (sel)
      2'b00:   idx = TAP_4K;
      2'b01:   idx = TAP_262K;
      2'b10:   idx = TAP_65K;
      default: idx = TAP_16K;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/timer_tick_edge.sv
// ---------------------------------------------------------------------------
// timer_tick_edge
//  Selects one bit of a free-running divider, gates it with an enable and
//  reports its falling edge. The falling edge is combinational against the
//  registered previous value, so any drop of the gated bit counts -- whether
//  the counter moved, the counter was cleared, the tap changed or the enable
//  dropped. That matches the DMG timer's glitchy increment behaviour and is
//  equally usable for the APU frame sequencer driven from a DIV bit.
// Ports
//  clk    in  1        clock, rising edge
//  rst    in  1        asynchronous, active-high
//  cnt    in  W        divider value
//  tap    in  clog2(W) bit index into cnt
//  en     in  1        gate for the selected bit
//  fall   out 1        selected&gated bit was 1 last cycle and is 0 now
// ---------------------------------------------------------------------------
module timer_tick_edge #(
  parameter int W = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         cnt,
  input  logic [$clog2(W)-1:0] tap,
  input  logic                 en,
  output logic                 fall
);

  logic tick;
  logic tick_q;

  assign tick = en & cnt[tap];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  assign fall = tick_q & ~tick;

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//  Sequencer for the DMG timer datapath (TIMA/TMA/TAC). Owns the system
//  divider, the TAC register, tick edge detection and the TIMA
//  overflow/reload FSM. Emits one-cycle control strobes to the TIMA datapath
//  (which holds TIMA/TMA) and the timer interrupt request. Runs at M-cycle
//  rate.
//
//  Strobe protocol: all strobes are single-cycle commands with no handshake;
//  the datapath acts on a strobe in the cycle it is high. At most one of
//  tima_inc / tima_load_cpu / tima_load_tma is high in any cycle.
//
// Ports
//  boga1mhz       in   1  M-cycle clock
//  reset          in   1  asynchronous, active-high
//  div_wr         in   1  CPU write to DIV (clears divider)
//  tac_wr         in   1  CPU write to TAC
//  tima_wr        in   1  CPU write to TIMA
//  tma_wr         in   1  CPU write to TMA
//  d_in           in   3  CPU data [2:0], taken on tac_wr
//  tima_carry     in   1  datapath TIMA == 8'hFF
//  div            out  8  DIV read value
//  tac_q          out  3  TAC register
//  tima_inc       out  1  increment TIMA
//  tima_load_cpu  out  1  load TIMA from CPU bus
//  tima_load_tma  out  1  load TIMA from TMA
//  tma_bypass     out  1  with tima_load_tma: use bus value being written to TMA
//  tima_zero      out  1  TIMA reads 8'h00 (overflow pending)
//  int_timer      out  1  timer interrupt request
//  state_dbg      out  2  current FSM state
// ---------------------------------------------------------------------------
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         boga1mhz,
  input  logic         reset,
  input  logic         div_wr,
  input  logic         tac_wr,
  input  logic         tima_wr,
  input  logic         tma_wr,
  input  logic [2:0]   d_in,
  input  logic         tima_carry,
  output logic [7:0]   div,
  output logic [2:0]   tac_q,
  output logic         tima_inc,
  output logic         tima_load_cpu,
  output logic         tima_load_tma,
  output logic         tma_bypass,
  output logic         tima_zero,
  output logic         int_timer,
  output timer_state_t state_dbg
);

  localparam int TAP_W = $clog2(CNT_W);

  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tap_idx;
  logic             tick_fall;
  timer_state_t     state;
  timer_state_t     state_nxt;

  // System divider; DIV is its top byte.
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (div_wr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign div = cnt[CNT_W-1 -: 8];

  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      tac_q <= 3'b000;
    end else if (tac_wr) begin
      tac_q <= d_in;
    end
  end

  assign tap_idx = TAP_W'(tac_tap(tac_q[1:0]));

  timer_tick_edge #(
    .W (CNT_W)
  ) u_tick_edge (
    .clk  (boga1mhz),
    .rst  (reset),
    .cnt  (cnt),
    .tap  (tap_idx),
    .en   (tac_q[2]),
    .fall (tick_fall)
  );

  // FSM state register
  always_ff @(posedge boga1mhz or posedge reset) begin
    if (reset) begin
      state <= TS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Mealy strobes. Strobes are held low while reset is
  // asserted so an asynchronous reset silences the datapath immediately.
  always_comb begin
    state_nxt     = state;
    tima_inc      = 1'b0;
    tima_load_cpu = 1'b0;
    tima_load_tma = 1'b0;
    tma_bypass    = 1'b0;
    if (!reset) begin
      case (state)
        TS_IDLE: begin
          // A CPU write to TIMA beats a coincident tick, so no overflow
          // can start in that cycle.
          if (tima_wr) begin
            tima_load_cpu = 1'b1;
          end else if (tick_fall) begin
            tima_inc = 1'b1;
            if (tima_carry) begin
              state_nxt = TS_OVF;
            end
          end
        end
        TS_OVF: begin
          // Writing TIMA while it reads zero cancels the pending reload.
          if (tima_wr) begin
            tima_load_cpu = 1'b1;
            state_nxt     = TS_IDLE;
          end else begin
            state_nxt = TS_RELOAD;
          end
        end
        TS_RELOAD: begin
          tima_load_tma = 1'b1;
          tma_bypass    = tma_wr;
          state_nxt     = TS_IDLE;
        end
        default: begin
          state_nxt = TS_IDLE;
        end
      endcase
    end
  end

  assign tima_zero = (state == TS_OVF);
  assign int_timer = (state == TS_RELOAD);
  assign state_dbg = state;

endmodule
